// File: rtl/bicubic_pkg.sv
// Shared constants and default coefficient generation for the bicubic tap filter.
// Latency: n/a (package only).
// Backpressure: n/a.
package bicubic_pkg;

    localparam int DATA_W    = 8;
    localparam int COEF_W    = 8;
    localparam int FRAC_BITS = 7;
    localparam int ACC_W     = DATA_W + COEF_W + 3;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Keys kernel (a = -0.5) at distance d/p, scaled by 2*p^3 so it stays integral.
    function automatic int keys_num(input int d, input int p);
        if (d <= p)
            return 3*d*d*d - 5*d*d*p + 2*p*p*p;
        else
            return -d*d*d + 5*d*d*p - 8*d*p*p + 4*p*p*p;
    endfunction

    // Divide rounding to nearest, halves away from zero.
    function automatic int round_div(input int n, input int den);
        if (n >= 0)
            return (n + den/2) / den;
        else
            return -((-n + den/2) / den);
    endfunction

    // Tap weight for phase ph; p1 absorbs rounding error so each phase sums to 2^frac_bits.
    function automatic int default_coef(input int phases, input int frac_bits, input int ph, input int tap);
        int den;
        int scale;
        int c0;
        int c1;
        int c2;
        int c3;
        int r;
        den   = 2*phases*phases*phases;
        scale = 1 << frac_bits;
        c0 = round_div(keys_num(phases + ph, phases) * scale, den);
        c2 = round_div(keys_num(phases - ph, phases) * scale, den);
        c3 = round_div(keys_num(2*phases - ph, phases) * scale, den);
        c1 = scale - c0 - c2 - c3;
        case (tap)
            0:       r = c0;
            1:       r = c1;
            2:       r = c2;
            default: r = c3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bicubic_tap_mac.sv
// One lane of the filter: registered products, registered sum, then round/clamp into the output register.
// Latency: 3 edges from S1 register to px.
// Backpressure: each register loads only on its enable, which the top derives from the global advance.
module bicubic_tap_mac #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int FRAC_BITS = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s2_en,
    input  logic                      s3_en,
    input  logic                      out_en,
    input  logic [4*DATA_W-1:0]       taps,
    input  logic [4*(COEF_W+1)-1:0]   coefs,
    output logic [DATA_W-1:0]         px
);

    localparam int CW    = COEF_W + 1;
    localparam int ACC_W = DATA_W + COEF_W + 3;
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(2**(FRAC_BITS-1));
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2**DATA_W - 1);

    logic signed [ACC_W-1:0] prod_d [4];
    logic signed [ACC_W-1:0] prod   [4];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] sh;
    logic [DATA_W-1:0]       px_d;

    // Unsigned pixel times signed coefficient, both widened to the accumulator width.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            prod_d[k] = ACC_W'($signed({1'b0, taps[k*DATA_W +: DATA_W]}))
                      * ACC_W'($signed(coefs[k*CW +: CW]));
        end
    end

    // S2: hold the four products.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) prod[k] <= '0;
        end else if (s2_en) begin
            for (int k = 0; k < 4; k++) prod[k] <= prod_d[k];
        end
    end

    // S3: hold the tap sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (s3_en)
            acc <= prod[0] + prod[1] + prod[2] + prod[3];
    end

    // Round half up, drop the fraction, clamp into the pixel range.
    always_comb begin
        rnd  = acc + RND;
        sh   = rnd >>> FRAC_BITS;
        px_d = sh[DATA_W-1:0];
        if (sh[ACC_W-1])
            px_d = '0;
        else if (sh > MAXV)
            px_d = '1;
    end

    // Output register holds the result until the top lets the pipe advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            px <= '0;
        else if (out_en)
            px <= px_d;
    end

endmodule

// File: rtl/bicubic_tap_filter.sv
// 4-tap bicubic interpolator, CHANNELS lanes sharing one phase; BICUBIC_COEF_LOAD_EN makes the table writable.
// Latency: sample accepted at edge N appears on out_px/out_valid at edge N+3; one sample per cycle.
// Backpressure: whole pipe stalls when out_valid & ~out_ready; in_ready mirrors the advance condition.
module bicubic_tap_filter #(
    parameter int DATA_W    = bicubic_pkg::DATA_W,
    parameter int COEF_W    = bicubic_pkg::COEF_W,
    parameter int FRAC_BITS = bicubic_pkg::FRAC_BITS,
    parameter int PHASES    = 4,
    parameter int CHANNELS  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [$clog2(PHASES)-1:0]       in_phase,
    input  logic [4*CHANNELS*DATA_W-1:0]    in_px,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CHANNELS*DATA_W-1:0]      out_px
`ifdef BICUBIC_COEF_LOAD_EN
    ,
    input  logic                            coef_we,
    input  logic [$clog2(PHASES)-1:0]       coef_phase,
    input  logic [1:0]                      coef_tap,
    input  logic [COEF_W-1:0]               coef_wdata
`endif
);

    import bicubic_pkg::*;

    localparam int CW = COEF_W + 1;

    logic [COEF_W-1:0]              coef_tab [PHASES][4];
    logic [4*CW-1:0]                coef_sel;
    logic [4*CW-1:0]                s1_coef;
    logic [4*CHANNELS*DATA_W-1:0]   s1_px;
    logic                           s1_vld;
    logic                           s2_vld;
    logic                           s3_vld;
    logic                           advance;
    logic                           accept;

`ifdef BICUBIC_COEF_LOAD_EN
    // Writable table, reloaded with the kernel on reset; writes ignore stall state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int ph = 0; ph < PHASES; ph++)
                for (int k = 0; k < 4; k++)
                    coef_tab[ph][k] <= COEF_W'(default_coef(PHASES, FRAC_BITS, ph, k));
        end else if (coef_we) begin
            coef_tab[coef_phase][coef_tap] <= coef_wdata;
        end
    end
`else
    for (genvar gp = 0; gp < PHASES; gp++) begin : g_rom_ph
        for (genvar gk = 0; gk < 4; gk++) begin : g_rom_tap
            localparam int C = default_coef(PHASES, FRAC_BITS, gp, gk);
            assign coef_tab[gp][gk] = COEF_W'(C);
        end
    end
`endif

    // Select the sample's phase; the most negative code is reserved for +2^(COEF_W-1) so unity gain fits.
    always_comb begin
        coef_sel = '0;
        for (int k = 0; k < 4; k++) begin
            if (coef_tab[in_phase][k] == {1'b1, {(COEF_W-1){1'b0}}})
                coef_sel[k*CW +: CW] = {2'b01, {(COEF_W-1){1'b0}}};
            else
                coef_sel[k*CW +: CW] = {coef_tab[in_phase][k][COEF_W-1], coef_tab[in_phase][k]};
        end
    end

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;

    // Stage valids shift together; bubbles travel as zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            s3_vld    <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            s1_vld    <= in_valid;
            s2_vld    <= s1_vld;
            s3_vld    <= s2_vld;
            out_valid <= s3_vld;
        end
    end

    // S1: capture taps and coefficients, so later table writes never touch in-flight samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_px   <= '0;
            s1_coef <= '0;
        end else if (accept) begin
            s1_px   <= in_px;
            s1_coef <= coef_sel;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        bicubic_tap_mac #(
            .DATA_W    (DATA_W),
            .COEF_W    (COEF_W),
            .FRAC_BITS (FRAC_BITS)
        ) u_mac (
            .clk    (clk),
            .rst    (rst),
            .s2_en  (advance & s1_vld),
            .s3_en  (advance & s2_vld),
            .out_en (advance & s3_vld),
            .taps   (s1_px[c*4*DATA_W +: 4*DATA_W]),
            .coefs  (s1_coef),
            .px     (out_px[c*DATA_W +: DATA_W])
        );
    end

endmodule
